// File: rtl/vga_csr_pkg.sv
// Shared types and constants for the VGA CSR bank.
// Holds the register index map, the active timing struct and the field
// positions used by the CSR decode and read mux.
package vga_csr_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef enum logic [ADDR_W-1:0] {
        CSR_CTRL = 4'd0,
        CSR_HTIM = 4'd1,
        CSR_VTIM = 4'd2,
        CSR_SYNC = 4'd3,
        CSR_STAT = 4'd4,
        CSR_IRQ  = 4'd5
    } csr_idx_e;

    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] h_total;
        logic [11:0] v_active;
        logic [11:0] v_total;
        logic [7:0]  hsync_w;
        logic [7:0]  vsync_w;
    } vga_timing_t;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_COMMIT_BIT = 1;
    localparam int TIM_W           = 12;
    localparam int TIM_LO_LSB      = 0;
    localparam int TIM_HI_LSB      = 16;
    localparam int SYNC_FIELD_W    = 8;
    localparam int HSYNC_LSB       = 0;
    localparam int VSYNC_LSB       = 8;
    localparam int STAT_PEND_BIT   = 0;
    localparam int STAT_CNT_LSB    = 16;
    localparam int FRAME_CNT_W     = 16;
    localparam int IRQ_DONE_BIT    = 0;

    // Builds the HTIM/VTIM read word from a {hi, lo} pair of 12-bit fields.
    function automatic logic [DATA_W-1:0] pack_tim(input logic [TIM_W-1:0] lo,
                                                    input logic [TIM_W-1:0] hi);
        logic [DATA_W-1:0] word;
        word = '0;
        word[TIM_LO_LSB +: TIM_W] = lo;
        word[TIM_HI_LSB +: TIM_W] = hi;
        return word;
    endfunction

endpackage

// File: rtl/vga_native_if.sv
// Native register port between the AXI-Lite slave FSM and the CSR bank.
// Word-indexed, full 32-bit writes, read data registered by the bank.
interface vga_native_if;
    import vga_csr_pkg::*;

    logic              write_en;
    logic [ADDR_W-1:0] addr_write;
    logic [DATA_W-1:0] data2native;
    logic              read_en_sync;
    logic [ADDR_W-1:0] addr_read;
    logic [DATA_W-1:0] data2axil;

    modport csr (
        input  write_en,
        input  addr_write,
        input  data2native,
        input  read_en_sync,
        input  addr_read,
        output data2axil
    );

endinterface

// File: rtl/vga_csr_shadow_reg.sv
// Staging/active register pair for one timing field group.
// Software writes land in staging; active only follows staging on commit,
// and because both update on the same edge a simultaneous write and commit
// moves the old staging value into active.
module vga_csr_shadow_reg #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] RST   = '0
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             commit,
    output logic [WIDTH-1:0] staging,
    output logic [WIDTH-1:0] active
);

    // Staging captures writes, active captures staging on commit.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            staging <= RST;
            active  <= RST;
        end else begin
            if (wr_en) begin
                staging <= wdata;
            end
            if (commit) begin
                active <= staging;
            end
        end
    end

endmodule

// File: rtl/vga_csr_bank.sv
// VGA timing CSR bank behind the native register port.
// Timing fields and CTRL.en are staged and only reach the sync generator on
// a frame boundary after software sets CTRL.commit. Also exposes the commit
// status and a frame counter.
// Optional feature: define VGA_CSR_IRQ_EN to add the frame_done sticky bit
// at index 5 and the irq_o output.
module vga_csr_bank
    import vga_csr_pkg::*;
#(
    parameter logic [11:0] H_ACTIVE_RST = 12'd640,
    parameter logic [11:0] H_TOTAL_RST  = 12'd800,
    parameter logic [11:0] V_ACTIVE_RST = 12'd480,
    parameter logic [11:0] V_TOTAL_RST  = 12'd525,
    parameter logic [7:0]  HSYNC_W_RST  = 8'd96,
    parameter logic [7:0]  VSYNC_W_RST  = 8'd2
) (
    input  logic         clk,
    input  logic         arst_n,
    vga_native_if.csr    native_if,
    input  logic         frame_start_i,
    output vga_timing_t  timing_o,
`ifdef VGA_CSR_IRQ_EN
    output logic         enable_o,
    output logic         irq_o
`else
    output logic         enable_o
`endif
);

    logic [DATA_W-1:0]      wdata;
    logic                   wr_ctrl;
    logic                   wr_htim;
    logic                   wr_vtim;
    logic                   wr_sync;
    logic                   commit;
    logic                   commit_pending;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [DATA_W-1:0]      rdata;
    logic                   unused_wdata;

    logic [2*TIM_W-1:0]        htim_stage;
    logic [2*TIM_W-1:0]        htim_act;
    logic [2*TIM_W-1:0]        vtim_stage;
    logic [2*TIM_W-1:0]        vtim_act;
    logic [2*SYNC_FIELD_W-1:0] sync_stage;
    logic [2*SYNC_FIELD_W-1:0] sync_act;
    logic                      en_stage;
    logic                      en_act;

    assign wdata        = native_if.data2native;
    assign unused_wdata = &{1'b0, wdata[DATA_W-1:TIM_HI_LSB+TIM_W]};

    assign wr_ctrl = native_if.write_en && (native_if.addr_write == CSR_CTRL);
    assign wr_htim = native_if.write_en && (native_if.addr_write == CSR_HTIM);
    assign wr_vtim = native_if.write_en && (native_if.addr_write == CSR_VTIM);
    assign wr_sync = native_if.write_en && (native_if.addr_write == CSR_SYNC);

    // A frame boundary only applies staging when a commit was already pending.
    assign commit = frame_start_i && commit_pending;

    vga_csr_shadow_reg #(
        .WIDTH (2*TIM_W),
        .RST   ({H_TOTAL_RST, H_ACTIVE_RST})
    ) u_htim (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (wr_htim),
        .wdata   ({wdata[TIM_HI_LSB +: TIM_W], wdata[TIM_LO_LSB +: TIM_W]}),
        .commit  (commit),
        .staging (htim_stage),
        .active  (htim_act)
    );

    vga_csr_shadow_reg #(
        .WIDTH (2*TIM_W),
        .RST   ({V_TOTAL_RST, V_ACTIVE_RST})
    ) u_vtim (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (wr_vtim),
        .wdata   ({wdata[TIM_HI_LSB +: TIM_W], wdata[TIM_LO_LSB +: TIM_W]}),
        .commit  (commit),
        .staging (vtim_stage),
        .active  (vtim_act)
    );

    vga_csr_shadow_reg #(
        .WIDTH (2*SYNC_FIELD_W),
        .RST   ({VSYNC_W_RST, HSYNC_W_RST})
    ) u_sync (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (wr_sync),
        .wdata   ({wdata[VSYNC_LSB +: SYNC_FIELD_W], wdata[HSYNC_LSB +: SYNC_FIELD_W]}),
        .commit  (commit),
        .staging (sync_stage),
        .active  (sync_act)
    );

    vga_csr_shadow_reg #(
        .WIDTH (1),
        .RST   (1'b0)
    ) u_en (
        .clk     (clk),
        .arst_n  (arst_n),
        .wr_en   (wr_ctrl),
        .wdata   (wdata[CTRL_EN_BIT]),
        .commit  (commit),
        .staging (en_stage),
        .active  (en_act)
    );

    assign timing_o.h_active = htim_act[TIM_W-1:0];
    assign timing_o.h_total  = htim_act[2*TIM_W-1:TIM_W];
    assign timing_o.v_active = vtim_act[TIM_W-1:0];
    assign timing_o.v_total  = vtim_act[2*TIM_W-1:TIM_W];
    assign timing_o.hsync_w  = sync_act[SYNC_FIELD_W-1:0];
    assign timing_o.vsync_w  = sync_act[2*SYNC_FIELD_W-1:SYNC_FIELD_W];
    assign enable_o          = en_act;

    // Commit request: cleared when applied, but a new request on the same edge wins.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            commit_pending <= 1'b0;
        end else begin
            if (commit) begin
                commit_pending <= 1'b0;
            end
            if (wr_ctrl && wdata[CTRL_COMMIT_BIT]) begin
                commit_pending <= 1'b1;
            end
        end
    end

    // Frame counter advances on each frame boundary while output is enabled.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            frame_cnt <= '0;
        end else if (frame_start_i && en_act) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef VGA_CSR_IRQ_EN
    logic frame_done;
    logic wr_irq;

    assign wr_irq = native_if.write_en && (native_if.addr_write == CSR_IRQ);
    assign irq_o  = frame_done;

    // Sticky frame-done flag; a new frame beats a same-cycle software clear.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            frame_done <= 1'b0;
        end else if (frame_start_i && en_act) begin
            frame_done <= 1'b1;
        end else if (wr_irq && wdata[IRQ_DONE_BIT]) begin
            frame_done <= 1'b0;
        end
    end
`endif

    // Read mux returns staging values so software sees what it last wrote.
    always_comb begin
        rdata = '0;
        case (native_if.addr_read)
            CSR_CTRL: rdata[CTRL_EN_BIT] = en_stage;
            CSR_HTIM: rdata = pack_tim(htim_stage[TIM_W-1:0], htim_stage[2*TIM_W-1:TIM_W]);
            CSR_VTIM: rdata = pack_tim(vtim_stage[TIM_W-1:0], vtim_stage[2*TIM_W-1:TIM_W]);
            CSR_SYNC: rdata[2*SYNC_FIELD_W-1:0] = sync_stage;
            CSR_STAT: begin
                rdata[STAT_PEND_BIT]                   = commit_pending;
                rdata[STAT_CNT_LSB +: FRAME_CNT_W]     = frame_cnt;
            end
`ifdef VGA_CSR_IRQ_EN
            CSR_IRQ:  rdata[IRQ_DONE_BIT] = frame_done;
`endif
            default:  rdata = '0;
        endcase
    end

    // Read data is captured on the request cycle and held until the next read.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            native_if.data2axil <= '0;
        end else if (native_if.read_en_sync) begin
            native_if.data2axil <= rdata;
        end
    end

endmodule
